serial_add_ctrl: RTL and testbench

Bit-serial addition controller that time-shares a single one-bit full adder cell across a WIDTH-bit addition. It latches two operands and a carry-in on a start handshake, then presents one bit pair per cycle (LSB first) to the external full adder. It captures the adder's sum and carry-out on each cycle and reports the WIDTH-bit result, carry-out and signed overflow with a done pulse. It sits between a requesting datapath and the full-adder instance, which is wired to the fa_* ports.

---
 rtl/serial_add_ctrl.sv | 134 +++++++++++++
 tb/tb_serial_add_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: streams WIDTH operand bit pairs LSB-first through an
// external one-bit full adder and assembles the registered sum, carry-out and overflow.
module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_c,
  input  logic             fa_s,
  input  logic             fa_co
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             msb_cin_q, msb_cin_d;
  logic             load;

  always_comb begin
    state_d   = state_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    sum_sh_d  = sum_sh_q;
    sum_d     = sum_q;
    cnt_d     = cnt_q;
    carry_d   = carry_q;
    cout_d    = cout_q;
    msb_cin_d = msb_cin_q;
    ready     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    fa_a      = 1'b0;
    fa_b      = 1'b0;
    fa_c      = 1'b0;
    load      = 1'b0;

    unique case (state_q)
      StIdle: begin
        ready = 1'b1;
        load  = start;
      end
      StRun: begin
        busy     = 1'b1;
        fa_a     = a_sh_q[0];
        fa_b     = b_sh_q[0];
        fa_c     = carry_q;
        sum_sh_d = {fa_s, sum_sh_q[WIDTH-1:1]};
        carry_d  = fa_co;
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          // Last bit: latch the result registers that stay visible until the next load.
          state_d   = StDone;
          cnt_d     = '0;
          msb_cin_d = carry_q;
          cout_d    = fa_co;
          sum_d     = {fa_s, sum_sh_q[WIDTH-1:1]};
        end
      end
      StDone: begin
        done    = 1'b1;
        ready   = 1'b1;
        load    = start;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      state_d   = StRun;
      a_sh_d    = a;
      b_sh_d    = b;
      carry_d   = cin;
      cnt_d     = '0;
      sum_sh_d  = '0;
      sum_d     = '0;
      cout_d    = 1'b0;
      msb_cin_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      sum_sh_q  <= '0;
      sum_q     <= '0;
      cnt_q     <= '0;
      carry_q   <= 1'b0;
      cout_q    <= 1'b0;
      msb_cin_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_sh_q    <= a_sh_d;
      b_sh_q    <= b_sh_d;
      sum_sh_q  <= sum_sh_d;
      sum_q     <= sum_d;
      cnt_q     <= cnt_d;
      carry_q   <= carry_d;
      cout_q    <= cout_d;
      msb_cin_q <= msb_cin_d;
    end
  end

  assign sum      = sum_q;
  assign cout     = cout_q;
  // Both terms are registered and cleared together, so overflow reads 0 outside a result.
  assign overflow = msb_cin_q ^ cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl: an 8-bit instance for the scenario vectors and a
// 4-bit instance for an exhaustive sweep, each wired to a behavioural full adder.
module tb_serial_add_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       start8, cin8, ready8, busy8, done8, cout8, ovf8;
  logic [7:0] a8, b8, sum8;
  logic       fa8_a, fa8_b, fa8_c, fa8_s, fa8_co;

  logic       start4, cin4, ready4, busy4, done4, cout4, ovf4;
  logic [3:0] a4, b4, sum4;
  logic       fa4_a, fa4_b, fa4_c, fa4_s, fa4_co;

  assign fa8_s  = fa8_a ^ fa8_b ^ fa8_c;
  assign fa8_co = (fa8_a & fa8_b) | (fa8_a & fa8_c) | (fa8_b & fa8_c);
  assign fa4_s  = fa4_a ^ fa4_b ^ fa4_c;
  assign fa4_co = (fa4_a & fa4_b) | (fa4_a & fa4_c) | (fa4_b & fa4_c);

  serial_add_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .ready(ready8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .overflow(ovf8),
    .fa_a(fa8_a), .fa_b(fa8_b), .fa_c(fa8_c), .fa_s(fa8_s), .fa_co(fa8_co)
  );

  serial_add_ctrl #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .ready(ready4), .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .overflow(ovf4),
    .fa_a(fa4_a), .fa_b(fa4_b), .fa_c(fa4_c), .fa_s(fa4_s), .fa_co(fa4_co)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Launch one 8-bit op; returns at the negedge where done is seen (or after the bound).
  task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                     output int cycles, output int busy_cnt);
    @(negedge clk);
    a8 = av; b8 = bv; cin8 = cv; start8 = 1'b1;
    @(negedge clk);
    start8   = 1'b0;
    cycles   = 1;
    busy_cnt = 0;
    while (!done8 && cycles < 40) begin
      if (busy8) busy_cnt++;
      @(negedge clk);
      cycles++;
    end
  endtask

  int cyc, bcnt, dcnt, t_first, t_second, sweep_err, fa_bad;
  logic [7:0] s_first, s_second;
  logic c_first, c_second, o_first, o_second;

  initial begin
    rst = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", ready8, 1);
    check("rst_busy_done", {busy8, done8}, 0);
    check("rst_result", {cout8, ovf8, sum8}, 0);
    check("rst_fa", {fa8_a, fa8_b, fa8_c}, 0);
    rst = 1'b0;

    op8(8'h5A, 8'h3C, 1'b0, cyc, bcnt);
    check("lat_5a3c", cyc, 9);
    check("busy_5a3c", bcnt, 8);
    check("sum_5a3c", {cout8, ovf8, sum8}, {1'b0, 1'b1, 8'h96});
    @(negedge clk);
    check("done_pulse_once", {done8, ready8}, 2'b01);
    check("sum_held", sum8, 8'h96);

    op8(8'hFF, 8'h01, 1'b0, cyc, bcnt);
    check("sum_ff01", {cout8, ovf8, sum8}, {1'b1, 1'b0, 8'h00});
    op8(8'h7F, 8'h00, 1'b1, cyc, bcnt);
    check("sum_7f00c", {cout8, ovf8, sum8}, {1'b0, 1'b1, 8'h80});

    // Second start during RUN must be ignored.
    @(negedge clk);
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    dcnt = 0; s_first = '0;
    for (int t = 0; t < 20; t++) begin
      if (done8) begin dcnt++; s_first = sum8; c_first = cout8; end
      @(negedge clk);
    end
    check("ignored_done_cnt", dcnt, 1);
    check("ignored_sum", {c_first, s_first}, {1'b0, 8'h46});
    check("ignored_idle", {ready8, busy8}, 2'b10);

    // Back-to-back with start held high.
    @(negedge clk);
    a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    dcnt = 0; t_first = 0; t_second = 0;
    for (int t = 1; t <= 30; t++) begin
      @(negedge clk);
      if (done8) begin
        dcnt++;
        if (dcnt == 1) begin
          t_first = t; s_first = sum8; c_first = cout8; o_first = ovf8;
          a8 = 8'h80; b8 = 8'h80;
        end else if (dcnt == 2) begin
          t_second = t; s_second = sum8; c_second = cout8; o_second = ovf8;
          start8 = 1'b0;
        end
      end
    end
    start8 = 1'b0;
    check("b2b_done_cnt", dcnt, 2);
    check("b2b_spacing", t_second - t_first, 9);
    check("b2b_first", {c_first, o_first, s_first}, {1'b0, 1'b0, 8'h02});
    check("b2b_second", {c_second, o_second, s_second}, {1'b1, 1'b1, 8'h00});

    // Reset during bit 4 of RUN.
    @(negedge clk);
    a8 = 8'h5A; b8 = 8'h3C; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_run_state", {ready8, busy8, done8}, 3'b100);
    check("rst_run_result", {cout8, ovf8, sum8}, 0);
    dcnt = 0;
    for (int t = 0; t < 12; t++) begin
      if (done8) dcnt++;
      @(negedge clk);
    end
    check("rst_run_no_done", dcnt, 0);
    op8(8'h11, 8'h22, 1'b1, cyc, bcnt);
    check("after_rst_sum", {cout8, sum8}, {1'b0, 8'h34});
    check("after_rst_lat", cyc, 9);

    // Exhaustive 4-bit sweep.
    sweep_err = 0; fa_bad = 0;
    for (int av = 0; av < 16; av++) begin
      for (int bv = 0; bv < 16; bv++) begin
        for (int cv = 0; cv < 2; cv++) begin
          @(negedge clk);
          a4 = 4'(av); b4 = 4'(bv); cin4 = 1'(cv); start4 = 1'b1;
          @(negedge clk);
          start4 = 1'b0;
          cyc = 1;
          while (!done4 && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (!busy4 && (fa4_a | fa4_b | fa4_c)) fa_bad++;
          end
          if (cyc != 5 || {cout4, sum4} !== 5'(av + bv + cv)) sweep_err++;
        end
      end
    end
    check("sweep_w4", sweep_err, 0);
    check("sweep_fa_idle", fa_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
